hazard_ctrl_pipe: RTL
=====================

Name: hazard_ctrl_pipe

Overview:
- Parametrised replacement for the single-cycle hazard control mux.
- Registers the decoded control word through STAGES pipeline stages (EX, MEM, WB by default).
- Inserts multi-cycle bubbles on hazard and squashes on branch flush.
- Drives stall_o back to the PC and IF/ID registers, and keeps a saturating bubble counter for performance monitoring.

Parameters:
- CTRL_W, 14: control word width. Fields: ALUop[3:0], ALUsrc, RegWrite, MemRead, MemWrite, MemToReg, RegDst[4:0].
- STAGES, 3: number of registered control stages.
- MAX_STALL, 3: maximum bubble cycles per hazard event.
- CNT_W, $clog2(MAX_STALL+1): stall length and counter width.
- PERF_W, 16: width of the bubble performance counter.

Ports:
- clk_i  in  1  clock, rising edge.
- rst_i  in  1  asynchronous reset, active-high.
- ctrl_i  in  CTRL_W  decoded control word from ID.
- valid_i  in  1  ID holds a real instruction.
- hazard_i  in  1  hazard detected for the ID instruction.
- stall_len_i  in  CNT_W  requested bubble cycles; sampled only when a hazard is accepted.
- flush_i  in  1  branch/jump taken; squash the ID instruction.
- perf_clr_i  in  1  synchronous clear of bubble_cnt_o.
- stall_o  out  1  hold PC and IF/ID this cycle.
- ctrl_o  out  STAGES*CTRL_W  registered control per stage; stage k occupies bits [k*CTRL_W +: CTRL_W].
- valid_o  out  STAGES  per-stage valid.
- busy_o  out  1  FSM in STALL.
- bubble_cnt_o  out  PERF_W  saturating count of inserted bubbles, hazard and flush.

Behaviour:
- Reset (async, rst_i=1):
  - All stage ctrl registers go to 0. All-zero is the bubble: no writes, no memory access.
  - valid_o=0, state=IDLE, cnt=0, bubble_cnt_o=0.
  - stall_o=0 and busy_o=0 while rst_i=1.
- Stall length clamp: N = stall_len_i, with 0 treated as 1 and values above MAX_STALL treated as MAX_STALL.
- FSM states are IDLE and STALL.
- IDLE:
  - If flush_i: stage0 takes a bubble, stall_o=0, stay IDLE.
  - Else if hazard_i && valid_i:
    - stall_o=1 combinationally in this same cycle; stage0 takes a bubble.
    - cnt <= N-1.
    - If N==1, stay IDLE; otherwise go to STALL.
  - Else: stage0 <= ctrl_i and valid0 <= valid_i. A control word with valid_i=0 is loaded as a bubble.
- STALL:
  - stall_o=1, busy_o=1, stage0 takes a bubble, cnt decrements.
  - When cnt==1 at the clock edge, go to IDLE.
  - STALL therefore lasts exactly N-1 cycles, for N bubble cycles total.
  - hazard_i is ignored while in STALL.
  - After returning to IDLE, the held ID instruction is re-evaluated; a new hazard starts a new stall.
- flush_i priority:
  - flush_i has highest priority in every state.
  - It forces a bubble into stage0, aborts STALL (state=IDLE, cnt=0) and forces stall_o=0 that cycle.
- Stages 1..STAGES-1 shift unconditionally every cycle (stage k <= stage k-1, including valid). There is no backpressure downstream of stage0.
- Latency: a non-stalled instruction appears on stage k exactly k+1 cycles after it is presented.
- bubble_cnt_o:
  - Increments by 1 on each cycle a bubble is forced into stage0 by a hazard, STALL or flush.
  - Saturates at 2^PERF_W-1.
  - perf_clr_i has priority over increment.
- Simultaneous hazard_i and flush_i: flush wins, there is no stall, and the counter increments once.
- Reset mid-STALL returns the block to IDLE immediately, with no residual stall.

Decomposition:
- Shared package holds:
  - CTRL_W.
  - Field LSB/width constants: ALUOP_LSB=10 (width 4), ALUSRC_BIT=9, REGWRITE_BIT=8, MEMREAD_BIT=7, MEMWRITE_BIT=6, MEMTOREG_BIT=5, REGDST_LSB=0 (width 5).
  - CTRL_BUBBLE = 0.
  - FSM state encoding: IDLE=0, STALL=1.
- Sub-module ctrl_stage_reg: one CTRL_W+1 register with bubble-select and async reset, instantiated STAGES times with a generate loop.

Test Plan:
- Reset release, then a valid ctrl_i=14'h2A5F with no hazard -> stage0 shows 14'h2A5F after 1 cycle and stage2 after 3 cycles; valid_o=3'b111 by cycle 3.
- hazard_i pulse with stall_len_i=1 -> stall_o high for 1 cycle, one zero bubble in stage0, busy_o stays 0, bubble_cnt_o=1.
- hazard_i with stall_len_i=3 (MAX_STALL=3) -> stall_o high 3 consecutive cycles, busy_o high cycles 2-3, three bubbles flow to stage2, bubble_cnt_o=3; stall_len_i=7 also gives exactly 3.
- flush_i asserted in the 2nd cycle of a 3-cycle stall -> stall_o drops that cycle, state=IDLE, stage0 bubble, next valid ctrl_i enters the following cycle.
- hazard_i and flush_i both high in the same cycle -> stall_o=0, one bubble, bubble_cnt_o +1.
- rst_i asserted asynchronously mid-STALL -> all outputs 0 immediately; bubble_cnt_o preset near 16'hFFFF saturates at 16'hFFFF under continued hazards; perf_clr_i gives 0.

Source files
------------

// File: rtl/hazard_ctrl_pipe_pkg.sv
// Shared constants for the hazard control pipe:
// control word layout, bubble value and FSM state encoding.
package hazard_ctrl_pipe_pkg;

   localparam int CTRL_W = 14;

   localparam int ALUOP_LSB    = 10;
   localparam int ALUOP_W      = 4;
   localparam int ALUSRC_BIT   = 9;
   localparam int REGWRITE_BIT = 8;
   localparam int MEMREAD_BIT  = 7;
   localparam int MEMWRITE_BIT = 6;
   localparam int MEMTOREG_BIT = 5;
   localparam int REGDST_LSB   = 0;
   localparam int REGDST_W     = 5;

   // All-zero word: no register write, no memory access.
   localparam logic [CTRL_W-1:0] CTRL_BUBBLE = '0;

   typedef enum logic {
      IDLE  = 1'b0,
      STALL = 1'b1
   } state_e;

endpackage

// File: rtl/hazard_ctrl_pipe_if.sv
// Handshake bundle between ID/hazard unit and the control pipe.
// slave: pipe side (ctrl_i..perf_clr_i in, stall_o..bubble_cnt_o out).
interface hazard_ctrl_pipe_if #(
   parameter int CTRL_W = hazard_ctrl_pipe_pkg::CTRL_W,
   parameter int STAGES = 3,
   parameter int CNT_W  = 2,
   parameter int PERF_W = 16
);
   logic [CTRL_W-1:0]        ctrl_i;
   logic                     valid_i;
   logic                     hazard_i;
   logic [CNT_W-1:0]         stall_len_i;
   logic                     flush_i;
   logic                     perf_clr_i;
   logic                     stall_o;
   logic [STAGES*CTRL_W-1:0] ctrl_o;
   logic [STAGES-1:0]        valid_o;
   logic                     busy_o;
   logic [PERF_W-1:0]        bubble_cnt_o;

   modport slave (
      input  ctrl_i, valid_i, hazard_i, stall_len_i,
      input  flush_i, perf_clr_i,
      output stall_o, ctrl_o, valid_o, busy_o, bubble_cnt_o
   );

   modport master (
      output ctrl_i, valid_i, hazard_i, stall_len_i,
      output flush_i, perf_clr_i,
      input  stall_o, ctrl_o, valid_o, busy_o, bubble_cnt_o
   );
endinterface

// File: rtl/hazard_ctrl_pipe_stage_reg.sv
// One control stage register {valid, ctrl} with bubble select.
// Ports: clk_i, rst_i (async high), d_i, bubble_i, q_o.
module ctrl_stage_reg #(
   parameter int W = 15
) (
   input  logic         clk_i,
   input  logic         rst_i,
   input  logic [W-1:0] d_i,
   input  logic         bubble_i,
   output logic [W-1:0] q_o
);
   logic [W-1:0] q_q;
   logic [W-1:0] q_d;

   assign q_d = bubble_i ? '0 : d_i;
   assign q_o = q_q;

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) q_q <= '0;
      else       q_q <= q_d;
   end
endmodule

// File: rtl/hazard_ctrl_pipe.sv
// Pipelined hazard control: bubbles, flush squash, stall and perf count.
// Ports: clk_i, rst_i (async high), bus (slave modport).
module hazard_ctrl_pipe #(
   parameter int CTRL_W    = hazard_ctrl_pipe_pkg::CTRL_W,
   parameter int STAGES    = 3,
   parameter int MAX_STALL = 3,
   parameter int CNT_W     = $clog2(MAX_STALL + 1),
   parameter int PERF_W    = 16
) (
   input logic              clk_i,
   input logic              rst_i,
   hazard_ctrl_pipe_if.slave bus
);
   import hazard_ctrl_pipe_pkg::*;

   state_e              state_q, state_d;
   logic [CNT_W-1:0]    cnt_q, cnt_d;
   logic [CNT_W-1:0]    n_len;
   logic [PERF_W-1:0]   perf_q, perf_d;
   logic                stall_c;
   logic                bubble_c;
   logic [CTRL_W:0]     stg [STAGES];

   // Requested length: 0 behaves as 1, clipped to MAX_STALL.
   always_comb begin
      n_len = bus.stall_len_i;
      if (bus.stall_len_i == '0)
         n_len = CNT_W'(1);
      else if (bus.stall_len_i > CNT_W'(MAX_STALL))
         n_len = CNT_W'(MAX_STALL);
   end

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      stall_c  = 1'b0;
      bubble_c = 1'b0;
      if (bus.flush_i) begin
         bubble_c = 1'b1;
         state_d  = IDLE;
         cnt_d    = '0;
      end else if (state_q == STALL) begin
         stall_c  = 1'b1;
         bubble_c = 1'b1;
         cnt_d    = cnt_q - CNT_W'(1);
         if (cnt_q == CNT_W'(1)) state_d = IDLE;
      end else if (bus.hazard_i && bus.valid_i) begin
         stall_c  = 1'b1;
         bubble_c = 1'b1;
         cnt_d    = n_len - CNT_W'(1);
         state_d  = (n_len == CNT_W'(1)) ? IDLE : STALL;
      end
   end

   always_comb begin
      perf_d = perf_q;
      if (bus.perf_clr_i)
         perf_d = '0;
      else if (bubble_c && !(&perf_q))
         perf_d = perf_q + PERF_W'(1);
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         perf_q  <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         perf_q  <= perf_d;
      end
   end

   for (genvar k = 0; k < STAGES; k++) begin : g_stage
      if (k == 0) begin : g_head
         // Invalid ID slots load as bubbles too.
         ctrl_stage_reg #(.W(CTRL_W + 1)) u_reg (
            .clk_i    (clk_i),
            .rst_i    (rst_i),
            .d_i      ({bus.valid_i, bus.ctrl_i}),
            .bubble_i (bubble_c | ~bus.valid_i),
            .q_o      (stg[k])
         );
      end else begin : g_tail
         ctrl_stage_reg #(.W(CTRL_W + 1)) u_reg (
            .clk_i    (clk_i),
            .rst_i    (rst_i),
            .d_i      (stg[k-1]),
            .bubble_i (1'b0),
            .q_o      (stg[k])
         );
      end
      assign bus.ctrl_o[k*CTRL_W +: CTRL_W] = stg[k][CTRL_W-1:0];
      assign bus.valid_o[k] = stg[k][CTRL_W];
   end

   // Hazard inputs may be live during reset; keep stall quiet.
   assign bus.stall_o      = stall_c & ~rst_i;
   assign bus.busy_o       = (state_q == STALL);
   assign bus.bubble_cnt_o = perf_q;
endmodule
